// File: rtl/multi_level_reduce_pipe.sv
// Registered N-bit reduction (AND/OR/XOR/XNOR) carried through a valid/ready pipeline with full backpressure.
// Optional saturating hit counter is enabled by defining REDUCE_PIPE_STATS_EN.
module multi_level_reduce_pipe #(
  parameter int IN_WIDTH  = 3,
  parameter int OUT_WIDTH = 3,
  parameter int STAGES    = 2
`ifdef REDUCE_PIPE_STATS_EN
  ,
  parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data
`ifdef REDUCE_PIPE_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] hit_count
`endif
);

  localparam logic [1:0] MODE_AND  = 2'd0;
  localparam logic [1:0] MODE_OR   = 2'd1;
  localparam logic [1:0] MODE_XOR  = 2'd2;
  localparam logic [1:0] MODE_XNOR = 2'd3;

  logic [STAGES:1]     valid;
  logic [STAGES:1]     adv;
  logic [IN_WIDTH-1:0] data_s1;
  logic [1:0]          mode_s1;
  logic [STAGES:2]     res;
  logic [STAGES:2]     res_next;
  logic                reduced;

  always_comb begin
    reduced = 1'b0;
    case (mode_s1)
      MODE_AND:  reduced = &data_s1;
      MODE_OR:   reduced = |data_s1;
      MODE_XOR:  reduced = ^data_s1;
      MODE_XNOR: reduced = ~^data_s1;
      default:   reduced = 1'b0;
    endcase
  end

  // Advance chain is resolved from the output backwards so a full pipe can move in lockstep.
  always_comb begin
    adv = '0;
    adv[STAGES] = valid[STAGES] && out_ready;
    for (int k = STAGES - 1; k >= 1; k--) begin
      adv[k] = valid[k] && (!valid[k+1] || adv[k+1]);
    end
  end

  always_comb begin
    res_next = '0;
    res_next[2] = reduced;
    for (int k = 3; k <= STAGES; k++) begin
      res_next[k] = res[k-1];
    end
  end

  assign in_ready  = !valid[1] || adv[1];
  assign out_valid = valid[STAGES];
  assign out_data  = {OUT_WIDTH{res[STAGES]}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= '0;
      data_s1 <= '0;
      mode_s1 <= '0;
      res     <= '0;
    end else begin
      if (in_ready) begin
        valid[1] <= in_valid;
        if (in_valid) begin
          data_s1 <= in_data;
          mode_s1 <= mode;
        end
      end
      // A stage reloads only when it is empty or its current word is moving on.
      for (int k = 2; k <= STAGES; k++) begin
        if (!valid[k] || adv[k]) begin
          valid[k] <= adv[k-1];
          if (adv[k-1]) begin
            res[k] <= res_next[k];
          end
        end
      end
    end
  end

`ifdef REDUCE_PIPE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count <= '0;
    end else if (adv[STAGES] && res[STAGES] && (hit_count != {CNT_WIDTH{1'b1}})) begin
      hit_count <= hit_count + CNT_WIDTH'(1);
    end
  end
`endif

endmodule
